// File: rtl/ir_car_pkg.sv
// Shared timing sets, field layout and mark-window helper for the car IR link.
// The transmitter and the receiver both use this package.
package ir_car_pkg;

    typedef struct packed {
        logic [11:0] hcyc_pulse;
        logic [7:0]  sz_start;
        logic [7:0]  sz_carsel;
        logic [7:0]  sz_gap;
        logic [7:0]  sz_assert;
        logic [7:0]  sz_deassert;
    } car_timing_t;

    // Field order: hcyc_pulse, start, carsel, gap, assert, deassert (all "minus 1").
    localparam car_timing_t TIMING_BLUE   = '{12'd1388, 8'd190, 8'd46, 8'd24, 8'd46, 8'd21};
    localparam car_timing_t TIMING_YELLOW = '{12'd1388, 8'd190, 8'd22, 8'd24, 8'd46, 8'd21};
    localparam car_timing_t TIMING_GREEN  = '{12'd1249, 8'd190, 8'd34, 8'd24, 8'd46, 8'd21};
    localparam car_timing_t TIMING_RED    = '{12'd1249, 8'd190, 8'd58, 8'd24, 8'd46, 8'd21};

    localparam logic [2:0] IDX_START    = 3'd0;
    localparam logic [2:0] IDX_CARSEL   = 3'd1;
    localparam logic [2:0] IDX_RIGHT    = 3'd2;
    localparam logic [2:0] IDX_LEFT     = 3'd3;
    localparam logic [2:0] IDX_BACKWARD = 3'd4;
    localparam logic [2:0] IDX_FORWARD  = 3'd5;

    localparam int CMD_RIGHT    = 0;
    localparam int CMD_LEFT     = 1;
    localparam int CMD_BACKWARD = 2;
    localparam int CMD_FORWARD  = 3;

    // True when n lies within target +/- tol; 9-bit signed so nothing wraps.
    function automatic logic in_window(input logic [7:0] n, input logic [8:0] target,
                                       input logic [7:0] tol);
        logic signed [8:0] diff;
        logic signed [8:0] lim;
        diff = $signed({1'b0, n}) - $signed(target);
        lim  = $signed({1'b0, tol});
        return (diff <= lim) && (diff >= -lim);
    endfunction

endpackage

// File: rtl/Generic_counter.sv
// Free-running wrap-around counter with synchronous clear; TRIG pulses on each wrap.
module Generic_counter #(
    parameter int CTR_WIDTH = 12,
    parameter int CTR_MAX   = 2777
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    input  logic CLEAR,
    output logic TRIG
);
    localparam logic [CTR_WIDTH-1:0] MAX_VAL = CTR_WIDTH'(CTR_MAX);

    logic [CTR_WIDTH-1:0] count_r;
    logic                 trig_r;

    // Count while enabled; wrap to zero at MAX_VAL and flag the wrap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_r <= '0;
            trig_r  <= 1'b0;
        end else if (CLEAR) begin
            count_r <= '0;
            trig_r  <= 1'b0;
        end else if (ENABLE) begin
            count_r <= (count_r == MAX_VAL) ? '0 : count_r + {{(CTR_WIDTH-1){1'b0}}, 1'b1};
            trig_r  <= (count_r == MAX_VAL);
        end else begin
            trig_r  <= 1'b0;
        end
    end

    assign TRIG = trig_r;

endmodule

// File: rtl/ir_envelope_detector.sv
// Synchronises the raw IR input, detects carrier rising edges and derives the
// burst envelope with one-cycle rise/fall strobes.
module ir_envelope_detector #(
    parameter int ENV_TIMEOUT = 4167
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ir_in,
    output logic edge_pulse,
    output logic env,
    output logic env_rise,
    output logic env_fall
);
    localparam logic [12:0] ENV_MAX  = 13'(ENV_TIMEOUT);
    localparam logic [12:0] ENV_LAST = 13'(ENV_TIMEOUT - 1);

    logic        sync1_r, sync2_r, prev_r;
    logic        edge_r, env_r, env_d_r;
    logic [12:0] env_ctr_r;
    logic        edge_s;

    assign edge_s = sync2_r & ~prev_r;

    // Envelope drops in the same cycle env_ctr reaches ENV_TIMEOUT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            prev_r    <= 1'b0;
            edge_r    <= 1'b0;
            env_r     <= 1'b0;
            env_d_r   <= 1'b0;
            env_ctr_r <= 13'd0;
        end else begin
            sync1_r <= ir_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            edge_r  <= edge_s;
            env_d_r <= env_r;
            if (edge_s) begin
                env_ctr_r <= 13'd0;
                env_r     <= 1'b1;
            end else begin
                if (env_ctr_r < ENV_MAX) begin
                    env_ctr_r <= env_ctr_r + 13'd1;
                end
                if (env_ctr_r >= ENV_LAST) begin
                    env_r <= 1'b0;
                end
            end
        end
    end

    assign edge_pulse = edge_r;
    assign env        = env_r;
    assign env_rise   = env_r & ~env_d_r;
    assign env_fall   = ~env_r & env_d_r;

endmodule

// File: rtl/ir_receiver_sm.sv
// Car-side IR packet decoder: measures marks and gaps of the envelope and
// recovers the 4-bit COMMAND, flagging good and rejected frames.
module ir_receiver_sm
    import ir_car_pkg::*;
#(
    parameter int HCYC_PULSE  = int'(TIMING_BLUE.hcyc_pulse),
    parameter int ENV_TIMEOUT = 4167,
    parameter int SZ_START    = int'(TIMING_BLUE.sz_start),
    parameter int SZ_CARSEL   = int'(TIMING_BLUE.sz_carsel),
    parameter int SZ_GAP      = int'(TIMING_BLUE.sz_gap),
    parameter int SZ_ASSERT   = int'(TIMING_BLUE.sz_assert),
    parameter int SZ_DEASSERT = int'(TIMING_BLUE.sz_deassert),
    parameter int TOL         = 4,
    // Default leaves 16 carrier periods of slack over the nominal gap.
    parameter int GAP_MAX     = SZ_GAP + 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IR_IN,
    output logic [3:0] COMMAND,
    output logic       PACKET_VALID,
    output logic       PACKET_ERROR,
    output logic       BUSY
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MARK  = 2'd1;
    localparam logic [1:0] ST_SPACE = 2'd2;

    localparam logic [8:0] TGT_START  = 9'(SZ_START + 1);
    localparam logic [8:0] TGT_CARSEL = 9'(SZ_CARSEL + 1);
    localparam logic [8:0] TGT_ONE    = 9'(SZ_ASSERT + 1);
    localparam logic [8:0] TGT_ZERO   = 9'(SZ_DEASSERT + 1);
    localparam logic [7:0] TOL_W      = 8'(TOL);
    localparam logic [7:0] GAP_LIM    = 8'(GAP_MAX);

    logic       edge_s, env_s, env_rise_s, env_fall_s, tick_s;
    logic [7:0] mark_cnt_r, gap_cnt_r;
    logic [1:0] state_r, state_n;
    logic [2:0] idx_r, idx_n, shadow_r, shadow_n;
    logic [3:0] command_r, command_n;
    logic       valid_r, valid_n, error_r, error_n, busy_r;
    logic       hit_start_s, hit_carsel_s, hit_one_s, hit_zero_s, accept_s, bit_s;

    ir_envelope_detector #(.ENV_TIMEOUT(ENV_TIMEOUT)) u_env (
        .CLK        (CLK),
        .RESET      (RESET),
        .ir_in      (IR_IN),
        .edge_pulse (edge_s),
        .env        (env_s),
        .env_rise   (env_rise_s),
        .env_fall   (env_fall_s)
    );

    Generic_counter #(.CTR_WIDTH(12), .CTR_MAX(2 * HCYC_PULSE + 1)) u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (~env_s),
        .CLEAR  (env_fall_s),
        .TRIG   (tick_s)
    );

    // Mark length in carrier edges (env_rise edge counts as the first) and gap length in ticks.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mark_cnt_r <= 8'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            if (env_rise_s) begin
                mark_cnt_r <= 8'd1;
            end else if (env_s && edge_s && (mark_cnt_r != 8'hFF)) begin
                mark_cnt_r <= mark_cnt_r + 8'd1;
            end
            if (env_fall_s) begin
                gap_cnt_r <= 8'd0;
            end else if (!env_s && tick_s && (gap_cnt_r != 8'hFF)) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end
        end
    end

    assign hit_start_s  = in_window(mark_cnt_r, TGT_START, TOL_W);
    assign hit_carsel_s = in_window(mark_cnt_r, TGT_CARSEL, TOL_W);
    assign hit_one_s    = in_window(mark_cnt_r, TGT_ONE, TOL_W);
    assign hit_zero_s   = in_window(mark_cnt_r, TGT_ZERO, TOL_W);

    // Mark classification for the current field; a 1 wins if both windows match.
    always_comb begin
        accept_s = 1'b0;
        bit_s    = 1'b0;
        case (idx_r)
            IDX_START:  accept_s = hit_start_s;
            IDX_CARSEL: accept_s = hit_carsel_s;
            IDX_RIGHT, IDX_LEFT, IDX_BACKWARD, IDX_FORWARD: begin
                accept_s = hit_one_s | hit_zero_s;
                bit_s    = hit_one_s;
            end
            default:    accept_s = 1'b0;
        endcase
    end

    // Frame sequencing; a bad START is treated as noise and dropped silently.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        shadow_n  = shadow_r;
        command_n = command_r;
        valid_n   = 1'b0;
        error_n   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (env_rise_s) begin
                    state_n = ST_MARK;
                    idx_n   = IDX_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (!env_fall_s) begin
                    state_n = ST_MARK;
                end else if (!accept_s) begin
                    state_n = ST_IDLE;
                    error_n = (idx_r != IDX_START);
                end else if (idx_r == IDX_FORWARD) begin
                    state_n   = ST_IDLE;
                    command_n = {bit_s, shadow_r};
                    valid_n   = 1'b1;
                end else begin
                    case (idx_r)
                        IDX_RIGHT:    shadow_n[0] = bit_s;
                        IDX_LEFT:     shadow_n[1] = bit_s;
                        IDX_BACKWARD: shadow_n[2] = bit_s;
                        default:      shadow_n    = shadow_r;
                    endcase
                    idx_n   = idx_r + 3'd1;
                    state_n = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (env_rise_s) begin
                    state_n = ST_MARK;
                end else if (gap_cnt_r > GAP_LIM) begin
                    state_n = ST_IDLE;
                    error_n = 1'b1;
                end else begin
                    state_n = ST_SPACE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            idx_r     <= 3'd0;
            shadow_r  <= 3'd0;
            command_r <= 4'd0;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            idx_r     <= idx_n;
            shadow_r  <= shadow_n;
            command_r <= command_n;
            valid_r   <= valid_n;
            error_r   <= error_n;
            busy_r    <= (state_n != ST_IDLE);
        end
    end

    assign COMMAND      = command_r;
    assign PACKET_VALID = valid_r;
    assign PACKET_ERROR = error_r;
    assign BUSY         = busy_r;

endmodule

// File: tb/tb_ir_receiver_sm.sv
// Randomised bench for ir_receiver_sm: carrier bursts are synthesised directly and
// outcomes are predicted by a frame-level model of the packet rules.
module tb_ir_receiver_sm;
    localparam int HCYC     = 1;
    localparam int ENV_TO   = 6;
    localparam int TOL      = 4;
    localparam int N_START  = 191;
    localparam int N_CARSEL = 47;
    localparam int N_ONE    = 47;
    localparam int N_ZERO   = 22;
    localparam int K_NONE   = 0;
    localparam int K_VALID  = 1;
    localparam int K_ERROR  = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       IR_IN = 1'b0;
    logic [3:0] COMMAND;
    logic       PACKET_VALID, PACKET_ERROR, BUSY;

    int tests = 0, fails = 0;
    int valid_cnt = 0, error_cnt = 0, both_seen = 0, cyc = 0, last_err_cyc = 0;
    logic [3:0] cmd_q[$];
    int mk[6];
    int mk_len;
    int exp_kind;
    logic [3:0] exp_new_cmd;
    logic [3:0] exp_cmd = 4'd0;

    ir_receiver_sm #(.HCYC_PULSE(HCYC), .ENV_TIMEOUT(ENV_TO)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IR_IN        (IR_IN),
        .COMMAND      (COMMAND),
        .PACKET_VALID (PACKET_VALID),
        .PACKET_ERROR (PACKET_ERROR),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (PACKET_VALID) begin
            valid_cnt = valid_cnt + 1;
            cmd_q.push_back(COMMAND);
        end
        if (PACKET_ERROR) begin
            error_cnt    = error_cnt + 1;
            last_err_cyc = cyc;
        end
        if (PACKET_VALID && PACKET_ERROR) both_seen = both_seen + 1;
    end

    function automatic bit near(input int n, input int target);
        return ((n - target) <= TOL) && ((target - n) <= TOL);
    endfunction

    // Frame-level rules: walk the fields, stop at the first mark that fits no window.
    function automatic void model_frame();
        logic [3:0] bits;
        bit ok;
        bits     = 4'd0;
        exp_kind = K_VALID;
        for (int i = 0; i < mk_len; i++) begin
            if (i == 0) ok = near(mk[0], N_START);
            else if (i == 1) ok = near(mk[1], N_CARSEL);
            else if (near(mk[i], N_ONE)) begin
                ok   = 1'b1;
                bits = bits | (4'd1 << (i - 2));
            end else ok = near(mk[i], N_ZERO);
            if (!ok) begin
                exp_kind = (i == 0) ? K_NONE : K_ERROR;
                return;
            end
        end
        if (mk_len < 6) exp_kind = K_ERROR;
        else exp_new_cmd = bits;
    endfunction

    task automatic set_frame(input logic [3:0] cmd);
        mk[0]  = N_START;
        mk[1]  = N_CARSEL;
        for (int i = 0; i < 4; i++) mk[2 + i] = cmd[i] ? N_ONE : N_ZERO;
        mk_len = 6;
    endtask

    task automatic send_mark(input int n);
        repeat (n) begin
            @(negedge CLK) IR_IN = 1'b1;
            @(negedge CLK);
            @(negedge CLK) IR_IN = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic send_gap(input int g);
        IR_IN = 1'b0;
        repeat (4 * g) @(negedge CLK);
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < mk_len; i++) begin
            send_mark(mk[i]);
            if (i < mk_len - 1) send_gap(gap);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (BUSY && n < 600) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (BUSY) begin
            fails++;
            $display("FAIL %s_timeout: BUSY still %0b after %0d cycles, expected 0", name, BUSY, n);
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        tests++; if (COMMAND !== 4'd0) begin fails++; $display("FAIL reset_cmd: got %h expected 0", COMMAND); end
        tests++; if (PACKET_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", PACKET_VALID); end
        tests++; if (PACKET_ERROR !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", PACKET_ERROR); end
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        RESET = 1'b0;
        send_gap(5);
    endtask

    task automatic test_clean_frame();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        set_frame(4'b1010);
        model_frame();
        send_frame(25);
        wait_idle("clean");
        tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL clean_valid: got %0d pulses expected 1", valid_cnt - v0); end
        tests++; if (error_cnt - e0 != 0) begin fails++; $display("FAIL clean_error: got %0d pulses expected 0", error_cnt - e0); end
        exp_cmd = exp_new_cmd;
        tests++; if (COMMAND !== exp_cmd) begin fails++; $display("FAIL clean_cmd: got %b expected %b", COMMAND, exp_cmd); end
    endtask

    task automatic test_back_to_back();
        int v0, e0;
        logic [3:0] first_cmd, second_cmd;
        v0 = valid_cnt; e0 = error_cnt;
        cmd_q.delete();
        set_frame(4'b0000); model_frame(); first_cmd = exp_new_cmd;
        send_frame(25);
        send_gap(25);
        set_frame(4'b1111); model_frame(); second_cmd = exp_new_cmd;
        send_frame(25);
        wait_idle("b2b");
        tests++; if (valid_cnt - v0 != 2) begin fails++; $display("FAIL b2b_valid: got %0d pulses expected 2", valid_cnt - v0); end
        tests++; if (error_cnt - e0 != 0) begin fails++; $display("FAIL b2b_error: got %0d pulses expected 0", error_cnt - e0); end
        tests++; if (cmd_q.size() < 2 || cmd_q[0] !== first_cmd || cmd_q[1] !== second_cmd) begin
            fails++;
            $display("FAIL b2b_cmds: got %p expected %b then %b", cmd_q, first_cmd, second_cmd);
        end
        exp_cmd = second_cmd;
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        set_frame(4'b1111);
        mk_len = 4;
        send_frame(25);
        send_gap(25);
        send_mark(20);
        #2 RESET = 1'b1;
        #1;
        exp_cmd = 4'd0;
        tests++; if (COMMAND !== exp_cmd || BUSY !== 1'b0 || PACKET_VALID !== 1'b0 || PACKET_ERROR !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got cmd=%b busy=%b v=%b e=%b expected all 0", COMMAND, BUSY, PACKET_VALID, PACKET_ERROR);
        end
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        send_gap(30);
        v0 = valid_cnt;
        set_frame(4'b0101); model_frame();
        send_frame(25);
        wait_idle("midreset");
        tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL midreset_valid: got %0d pulses expected 1", valid_cnt - v0); end
        exp_cmd = exp_new_cmd;
        tests++; if (COMMAND !== exp_cmd) begin fails++; $display("FAIL midreset_cmd: got %b expected %b", COMMAND, exp_cmd); end
    endtask

    task automatic test_tolerance();
        int tbl[7][6];
        int tlen[7];
        int v0, e0, ev, ee;
        tbl  = '{'{195, 43, 51, 18, 43, 26}, '{187, 51, 26, 43, 18, 51},
                 '{191, 47, 42, 0, 0, 0},    '{191, 47, 52, 0, 0, 0},
                 '{196, 0, 0, 0, 0, 0},      '{191, 300, 0, 0, 0, 0},
                 '{191, 47, 47, 17, 0, 0}};
        tlen = '{6, 6, 3, 3, 1, 2, 4};
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < 6; i++) mk[i] = tbl[c][i];
            mk_len = tlen[c];
            model_frame();
            v0 = valid_cnt; e0 = error_cnt;
            send_frame(25);
            wait_idle("tol");
            ev = (exp_kind == K_VALID) ? 1 : 0;
            ee = (exp_kind == K_ERROR) ? 1 : 0;
            if (exp_kind == K_VALID) exp_cmd = exp_new_cmd;
            tests++; if (valid_cnt - v0 != ev || error_cnt - e0 != ee) begin
                fails++;
                $display("FAIL tol_case%0d_pulses: got valid=%0d error=%0d expected valid=%0d error=%0d",
                         c, valid_cnt - v0, error_cnt - e0, ev, ee);
            end
            tests++; if (COMMAND !== exp_cmd) begin fails++; $display("FAIL tol_case%0d_cmd: got %b expected %b", c, COMMAND, exp_cmd); end
            send_gap(10);
        end
    endtask

    task automatic test_start_only();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        send_mark(100);
        wait_idle("start_only");
        tests++; if (error_cnt - e0 != 0 || valid_cnt - v0 != 0) begin
            fails++;
            $display("FAIL start_only_pulses: got valid=%0d error=%0d expected 0 and 0", valid_cnt - v0, error_cnt - e0);
        end
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL start_only_busy: got %b expected 0", BUSY); end
        tests++; if (COMMAND !== exp_cmd) begin fails++; $display("FAIL start_only_cmd: got %b expected %b", COMMAND, exp_cmd); end
    endtask

    task automatic test_truncated();
        int e0, t_end, dt;
        e0 = error_cnt;
        set_frame(4'b0011);
        mk_len = 4;
        model_frame();
        send_frame(25);
        t_end = cyc;
        wait_idle("trunc");
        tests++; if (exp_kind != K_ERROR || error_cnt - e0 != 1) begin
            fails++;
            $display("FAIL trunc_error: got %0d pulses expected 1 (model kind %0d)", error_cnt - e0, exp_kind);
        end
        dt = last_err_cyc - t_end;
        tests++; if (dt < 160 || dt > 190) begin
            fails++;
            $display("FAIL trunc_delay: got %0d clocks after mark end, expected 160..190", dt);
        end
        tests++; if (COMMAND !== exp_cmd) begin fails++; $display("FAIL trunc_cmd: got %b expected %b", COMMAND, exp_cmd); end
    endtask

    task automatic test_random();
        int v0, e0, ev, ee, j, nom;
        for (int f = 0; f < 10; f++) begin
            set_frame(4'($urandom_range(0, 15)));
            for (int i = 0; i < 6; i++) begin
                nom = mk[i];
                if ($urandom_range(0, 9) == 0) begin
                    j = TOL + 1 + int'($urandom_range(0, 2));
                    if ($urandom_range(0, 1) == 1) j = -j;
                end else begin
                    j = int'($urandom_range(0, 2 * TOL)) - TOL;
                end
                mk[i] = nom + j;
            end
            model_frame();
            v0 = valid_cnt; e0 = error_cnt;
            send_frame(int'($urandom_range(20, 28)));
            wait_idle("rand");
            ev = (exp_kind == K_VALID) ? 1 : 0;
            ee = (exp_kind == K_ERROR) ? 1 : 0;
            if (exp_kind == K_VALID) exp_cmd = exp_new_cmd;
            tests++; if (valid_cnt - v0 != ev || error_cnt - e0 != ee) begin
                fails++;
                $display("FAIL rand%0d_pulses: got valid=%0d error=%0d expected valid=%0d error=%0d marks=%p",
                         f, valid_cnt - v0, error_cnt - e0, ev, ee, mk);
            end
            tests++; if (COMMAND !== exp_cmd) begin fails++; $display("FAIL rand%0d_cmd: got %b expected %b", f, COMMAND, exp_cmd); end
            send_gap(10);
        end
    endtask

    task automatic test_exclusive();
        tests++;
        if (both_seen != 0) begin
            fails++;
            $display("FAIL exclusive: got %0d cycles with VALID and ERROR together, expected 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_tolerance();
        test_start_only();
        test_truncated();
        test_random();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
